// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and default widths for the two-requester RAM port arbiter.
//   state_e  : controller sequence IDLE -> ISSUE -> (WAIT -> RESP) -> IDLE
//   owner_e  : which requester owns the access currently in flight
// ----------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_RD_LAT     = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

   // A one-hot grant always names exactly one owner; bit 1 set means m1.
   function automatic owner_e onehot_to_owner(input logic [1:0] grant_onehot);
      return grant_onehot[1] ? OWN_M1 : OWN_M0;
   endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// ----------------------------------------------------------------------------
// ram_arb_rr2
// Two-way grant logic for the RAM port arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN defined -> m0 always wins a tie and no
// pointer register exists; undefined (default) -> round-robin between m0/m1.
// Ports:
//   clk           in   clock
//   rst           in   synchronous reset, active-high (pointer -> m0 first)
//   req[1:0]      in   request vector, bit0 = m0, bit1 = m1
//   gnt_en        in   grants may be issued this cycle (controller idle)
//   grant_onehot  out  one-hot grant, zero when nothing is granted
// ----------------------------------------------------------------------------
module ram_arb_rr2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       gnt_en,
   output logic [1:0] grant_onehot
);

`ifdef RAM_ARB_FIXED_PRIO_EN

   always_comb begin
      grant_onehot = 2'b00;
      if (gnt_en) begin
         if (req[0]) begin
            grant_onehot = 2'b01;
         end else if (req[1]) begin
            grant_onehot = 2'b10;
         end
      end
   end

`else

   // prefer_m1 marks the requester NOT served last; it only moves on a grant.
   logic prefer_m1;

   always_comb begin
      grant_onehot = 2'b00;
      if (gnt_en) begin
         unique case (req)
            2'b01:   grant_onehot = 2'b01;
            2'b10:   grant_onehot = 2'b10;
            2'b11:   grant_onehot = prefer_m1 ? 2'b10 : 2'b01;
            default: grant_onehot = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prefer_m1 <= 1'b0;
      end else if (|grant_onehot) begin
         prefer_m1 <= grant_onehot[0];
      end
   end

`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port RAM between two requesters. Each grant produces
// exactly one RAM access; reads return data with a one-cycle rvalid pulse.
// Build option: RAM_ARB_FIXED_PRIO_EN (see ram_arb_rr2) selects fixed m0
// priority instead of round-robin.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mX_req/wr_rdn/addr/wdata      requester X access request (held to gnt)
//   mX_gnt                        1-cycle accept; fields sampled that cycle
//   mX_rvalid/rdata               read completion pulse and held read data
//   ram_en/wr_rdn/addr/wdata      RAM command port
//   ram_data_rd                   RAM read data, valid RD_LAT cycles after en
//
// state | meaning
// IDLE  | no access in flight; grant a waiting requester and latch its fields
// ISSUE | drive ram_en for one cycle with the latched command
// WAIT  | read in flight; down-counter runs out the RAM read latency
// RESP  | pulse the owner's rvalid, then back to IDLE
// ----------------------------------------------------------------------------
import ram_arb_pkg::*;

module ram_port_arbiter #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RD_LAT     = DEF_RD_LAT
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  m0_req,
   input  logic                  m0_wr_rdn,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,

   input  logic                  m1_req,
   input  logic                  m1_wr_rdn,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,

   output logic                  ram_en,
   output logic                  ram_wr_rdn,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_data_rd
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

   state_e                  state_q;
   state_e                  state_d;
   owner_e                  owner_q;
   logic                    lat_wr_rdn_q;
   logic [ADDR_WIDTH-1:0]   lat_addr_q;
   logic [DATA_WIDTH-1:0]   lat_wdata_q;
   logic [CNT_W-1:0]        wait_cnt_q;
   logic                    wait_done;
   logic [1:0]              req_vec;
   logic [1:0]              grant_oh;
   logic                    gnt_en;

   assign req_vec   = {m1_req, m0_req};
   // Holding off grants during rst keeps reset free of side effects even
   // though the grant path is combinational.
   assign gnt_en    = (state_q == IDLE) && !rst;
   assign wait_done = (state_q == WAIT) && (wait_cnt_q == '0);

   ram_arb_rr2 u_rr2 (
      .clk          (clk),
      .rst          (rst),
      .req          (req_vec),
      .gnt_en       (gnt_en),
      .grant_onehot (grant_oh)
   );

   assign m0_gnt = grant_oh[0];
   assign m1_gnt = grant_oh[1];

   // The command bus is driven straight from the latch registers; only
   // ram_en qualifies it.
   assign ram_addr  = lat_addr_q;
   assign ram_wdata = lat_wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // rst gates the strobes so ram_en and rvalid drop in the same cycle rst
   // is raised, not one edge later.
   always_comb begin
      state_d    = state_q;
      ram_en     = 1'b0;
      ram_wr_rdn = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|grant_oh) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ram_en     = !rst;
            ram_wr_rdn = !rst && lat_wr_rdn_q;
            state_d    = lat_wr_rdn_q ? IDLE : WAIT;
         end
         WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = RESP;
            end
         end
         RESP: begin
            m0_rvalid = !rst && (owner_q == OWN_M0);
            m1_rvalid = !rst && (owner_q == OWN_M1);
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= OWN_M0;
         lat_wr_rdn_q <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
      end else if (|grant_oh) begin
         owner_q      <= onehot_to_owner(grant_oh);
         lat_wr_rdn_q <= grant_oh[1] ? m1_wr_rdn : m0_wr_rdn;
         lat_addr_q   <= grant_oh[1] ? m1_addr   : m0_addr;
         lat_wdata_q  <= grant_oh[1] ? m1_wdata  : m0_wdata;
      end
   end

   // Loaded with RD_LAT-1 while issuing so that WAIT lasts exactly RD_LAT
   // cycles; terminal count is zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else if (state_q == ISSUE) begin
         wait_cnt_q <= CNT_LOAD;
      end else if ((state_q == WAIT) && (wait_cnt_q != '0)) begin
         wait_cnt_q <= wait_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else if (wait_done) begin
         if (owner_q == OWN_M0) begin
            m0_rdata <= ram_data_rd;
         end else begin
            m1_rdata <= ram_data_rd;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int RDL = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_wr_rdn, m0_gnt, m0_rvalid;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_wr_rdn, m1_gnt, m1_rvalid;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          ram_en, ram_wr_rdn;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_data_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RDL)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr_rdn(m0_wr_rdn), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr_rdn(m1_wr_rdn), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_wr_rdn(ram_wr_rdn), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_data_rd(ram_data_rd)
   );

   // RAM model with RDL cycles of read latency
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_pipe [0:RDL-1];

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wr_rdn) mem[ram_addr] <= ram_wdata;
         else            rd_pipe[0]    <= mem[ram_addr];
      end
      for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_data_rd = rd_pipe[RDL-1];

   // cycle counter and event counters
   int cyc = 0;
   int n_en = 0, n_wr = 0, n_g0 = 0, n_g1 = 0, n_rv0 = 0, n_rv1 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ram_en)             n_en  <= n_en + 1;
      if (ram_en && ram_wr_rdn) n_wr <= n_wr + 1;
      if (m0_gnt)             n_g0  <= n_g0 + 1;
      if (m1_gnt)             n_g1  <= n_g1 + 1;
      if (m0_rvalid)          n_rv0 <= n_rv0 + 1;
      if (m1_rvalid)          n_rv1 <= n_rv1 + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Raise a request, wait for its grant, drop it after the granting edge.
   // Returns the cycle the request was raised and the cycle of the grant.
   task automatic issue_req(input int m, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int rcyc, output int gcyc);
      gcyc = -1;
      rcyc = cyc;
      if (m == 0) begin
         m0_req = 1'b1; m0_wr_rdn = wr; m0_addr = a; m0_wdata = d;
      end else begin
         m1_req = 1'b1; m1_wr_rdn = wr; m1_addr = a; m1_wdata = d;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_gnt : m1_gnt) begin
            gcyc = cyc;
            break;
         end
         tick();
      end
      tick();
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
      checks++;
      if (gcyc < 0) begin
         errors++;
         $display("FAIL issue_req_gnt m%0d: actual no gnt in 40 cycles, required gnt", m);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m0_req = 1'b1; m0_wr_rdn = 1'b1; m0_addr = 10'h001; m0_wdata = 32'h1;
      m1_req = 1'b0; m1_wr_rdn = 1'b0; m1_addr = '0; m1_wdata = '0;
      idle(3);
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== 2'b00) begin
         errors++; $display("FAIL reset_gnt: actual %b required 00", {m0_gnt, m1_gnt});
      end
      checks++;
      if ({ram_en, ram_wr_rdn, m0_rvalid, m1_rvalid} !== 4'b0000) begin
         errors++; $display("FAIL reset_strobes: actual %b required 0000",
                            {ram_en, ram_wr_rdn, m0_rvalid, m1_rvalid});
      end
      checks++;
      if (ram_addr !== '0 || ram_wdata !== '0) begin
         errors++; $display("FAIL reset_ram_bus: actual addr %h wdata %h required 0 0", ram_addr, ram_wdata);
      end
      checks++;
      if (m0_rdata !== '0 || m1_rdata !== '0) begin
         errors++; $display("FAIL reset_rdata: actual %h %h required 0 0", m0_rdata, m1_rdata);
      end
      tick();
      m0_req = 1'b0;
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_write();
      int rc, g, en0, wr0, rv0;
      en0 = n_en; wr0 = n_wr; rv0 = n_rv0 + n_rv1;
      issue_req(0, 1'b1, 10'h005, 32'hDEADBEEF, rc, g);
      checks++;
      if (g != rc) begin
         errors++; $display("FAIL write_gnt_cycle: actual %0d required %0d", g, rc);
      end
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b1 || ram_wr_rdn !== 1'b1 || ram_addr !== 10'h005 || ram_wdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL write_issue: actual en %b wr %b addr %h data %h required 1 1 005 deadbeef",
                            ram_en, ram_wr_rdn, ram_addr, ram_wdata);
      end
      idle(5);
      checks++;
      if (n_en - en0 != 1 || n_wr - wr0 != 1) begin
         errors++; $display("FAIL write_en_count: actual en %0d wr %0d required 1 1", n_en - en0, n_wr - wr0);
      end
      checks++;
      if (n_rv0 + n_rv1 - rv0 != 0) begin
         errors++; $display("FAIL write_no_rvalid: actual %0d required 0", n_rv0 + n_rv1 - rv0);
      end
      checks++;
      if (mem[5] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL write_mem: actual %h required deadbeef", mem[5]);
      end
   endtask

   task automatic test_read();
      int rc, g, r, rv0, rv1;
      rv0 = n_rv0; rv1 = n_rv1; r = -1;
      issue_req(1, 1'b0, 10'h005, 32'h0, rc, g);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m1_rvalid) begin
            r = cyc;
            break;
         end
      end
      checks++;
      if (r != g + 1 + RDL + 1) begin
         errors++; $display("FAIL read_latency: actual cycle %0d required %0d", r, g + 1 + RDL + 1);
      end
      checks++;
      if (m1_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL read_data: actual %h required deadbeef", m1_rdata);
      end
      @(negedge clk);
      checks++;
      if (m1_rvalid !== 1'b0) begin
         errors++; $display("FAIL read_rvalid_width: actual %b required 0", m1_rvalid);
      end
      idle(3);
      checks++;
      if (n_rv1 - rv1 != 1 || n_rv0 - rv0 != 0 || m0_rdata !== '0) begin
         errors++; $display("FAIL read_owner_only: actual rv1 %0d rv0 %0d m0_rdata %h required 1 0 0",
                            n_rv1 - rv1, n_rv0 - rv0, m0_rdata);
      end
   endtask

   task automatic test_round_robin();
      int exp_w [4];
      int w;
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_w = '{0, 0, 0, 0};
`else
      exp_w = '{0, 1, 0, 1};
`endif
      for (int r = 0; r < 4; r++) begin
         m0_req = 1'b1; m0_wr_rdn = 1'b1; m0_addr = AW'(10'h040 + r); m0_wdata = 32'hA000_0000 + r;
         m1_req = 1'b1; m1_wr_rdn = 1'b1; m1_addr = AW'(10'h080 + r); m1_wdata = 32'hB000_0000 + r;
         @(negedge clk);
         w = (m0_gnt && !m1_gnt) ? 0 : ((m1_gnt && !m0_gnt) ? 1 : -1);
         checks++;
         if (w != exp_w[r]) begin
            errors++; $display("FAIL rr_round%0d: actual winner %0d required %0d", r, w, exp_w[r]);
         end
         tick();
         m0_req = 1'b0; m1_req = 1'b0;
         idle(3);
      end
   endtask

   task automatic test_busy_hold();
      int rc, g, c, gc0, rv, g1;
      issue_req(1, 1'b1, 10'h3FF, 32'h12345678, rc, g);
      idle(3);
      gc0 = -1; rv = -1; g1 = -1;
      c = cyc;
      m0_req = 1'b1; m0_wr_rdn = 1'b0; m0_addr = 10'h3FF;
      m1_wr_rdn = 1'b1; m1_addr = 10'h100; m1_wdata = 32'hA5A5A5A5;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m0_gnt && gc0 < 0) gc0 = cyc;
         if (m0_rvalid && rv < 0) rv = cyc;
         if (m1_gnt && g1 < 0) g1 = cyc;
         tick();
         if (gc0 >= 0) begin
            m0_req = 1'b0;
            m1_req = (g1 < 0);
         end
      end
      m1_req = 1'b0;
      checks++;
      if (gc0 != c || rv != c + RDL + 2) begin
         errors++; $display("FAIL busy_m0: actual gnt %0d rvalid %0d required %0d %0d", gc0, rv, c, c + RDL + 2);
      end
      checks++;
      if (g1 != rv + 1) begin
         errors++; $display("FAIL busy_m1_gnt: actual cycle %0d required %0d", g1, rv + 1);
      end
      checks++;
      if (m0_rdata !== 32'h12345678) begin
         errors++; $display("FAIL busy_rdata: actual %h required 12345678", m0_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int rc, g, rvs;
      rvs = n_rv0 + n_rv1;
      issue_req(0, 1'b0, 10'h005, 32'h0, rc, g);
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0 || m0_rvalid !== 1'b0) begin
         errors++; $display("FAIL rst_wait_strobes: actual en %b rvalid %b required 0 0", ram_en, m0_rvalid);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (m0_rdata !== '0) begin
         errors++; $display("FAIL rst_wait_rdata: actual %h required 0", m0_rdata);
      end
      idle(8);
      issue_req(0, 1'b0, 10'h005, 32'h0, rc, g);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b0) begin
         errors++; $display("FAIL rst_issue_en: actual %b required 0", ram_en);
      end
      tick();
      rst = 1'b0;
      idle(8);
      issue_req(1, 1'b1, 10'h020, 32'hCAFEF00D, rc, g);
      checks++;
      if (g != rc) begin
         errors++; $display("FAIL rst_regrant: actual cycle %0d required %0d", g, rc);
      end
      @(negedge clk);
      checks++;
      if (ram_en !== 1'b1 || ram_wr_rdn !== 1'b1 || ram_addr !== 10'h020) begin
         errors++; $display("FAIL rst_regrant_issue: actual en %b wr %b addr %h required 1 1 020",
                            ram_en, ram_wr_rdn, ram_addr);
      end
      idle(4);
      checks++;
      if (n_rv0 + n_rv1 - rvs != 0) begin
         errors++; $display("FAIL rst_no_rvalid: actual %0d required 0", n_rv0 + n_rv1 - rvs);
      end
   endtask

   task automatic test_dropped_req();
      int rc, g, en0, g10, rv0;
      en0 = n_en; g10 = n_g1; rv0 = n_rv0;
      issue_req(0, 1'b0, 10'h005, 32'h0, rc, g);
      tick();
      m1_req = 1'b1; m1_wr_rdn = 1'b1; m1_addr = 10'h077; m1_wdata = 32'h0BAD0BAD;
      tick();
      m1_req = 1'b0;
      idle(10);
      checks++;
      if (n_g1 - g10 != 0 || n_en - en0 != 1) begin
         errors++; $display("FAIL dropped_req: actual m1_gnt %0d ram_en %0d required 0 1", n_g1 - g10, n_en - en0);
      end
      checks++;
      if (n_rv0 - rv0 != 1 || m0_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL dropped_req_m0_read: actual rv %0d data %h required 1 deadbeef",
                            n_rv0 - rv0, m0_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_busy_hold();
      test_reset_mid();
      test_dropped_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
